// File: rtl/icache_assoc_if.sv
// rtl/icache_assoc_if.sv - fetch and instruction-memory handshake bundle for icache_assoc
interface icache_assoc_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_addr, mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, mem_ren, mem_raddr
    );

    modport master (
        output req_valid, req_addr, mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, mem_ren, mem_raddr
    );
endinterface

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - fully-associative instruction cache with true-LRU replacement
module icache_assoc #(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    icache_assoc_if.slave    bus,
    input  logic             flush,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, MREQ, MWAIT} state_t;

    state_t              state_q;
    logic [ENTRIES-1:0]  valid_q;
    logic [ADDR_W-1:0]   tag_q  [ENTRIES];
    logic [DATA_W-1:0]   data_q [ENTRIES];
    logic [IDX_W-1:0]    age_q  [ENTRIES];
    logic [ADDR_W-1:0]   addr_q;
    logic [IDX_W-1:0]    victim_q;
    logic                flush_pend_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                mem_ren_q;
    logic [ADDR_W-1:0]   mem_raddr_q;
    logic [CNT_W-1:0]    hit_q;
    logic [CNT_W-1:0]    miss_q;

    logic                req_ready_w;
    logic                accept;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [IDX_W-1:0]    victim_d;
    logic                fill;
    logic                touch_en;
    logic [IDX_W-1:0]    touch_idx;

    assign req_ready_w = (state_q == IDLE) && !flush;
    assign accept      = bus.req_valid && req_ready_w;
    assign fill        = (state_q == MWAIT) && bus.mem_ready;
    assign touch_en    = (accept && hit) || fill;
    assign touch_idx   = fill ? victim_q : hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == bus.req_addr)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Oldest line by default; a free line (lowest index) overrides it.
    always_comb begin
        victim_d = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (age_q[i] == IDX_W'(ENTRIES - 1)) victim_d = IDX_W'(i);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim_d = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            addr_q       <= '0;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mem_ren_q    <= 1'b0;
            mem_raddr_q  <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                age_q[i]  <= IDX_W'(i);
            end
        end else begin
            resp_valid_q <= 1'b0;
            mem_ren_q    <= 1'b0;

            // Touched line becomes youngest; only lines younger than it age by one.
            if (touch_en) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (IDX_W'(j) == touch_idx)         age_q[j] <= '0;
                    else if (age_q[j] < age_q[touch_idx]) age_q[j] <= age_q[j] + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (accept) begin
                        if (hit) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= data_q[hit_idx];
                            if (hit_q != '1) hit_q <= hit_q + 1'b1;
                        end else begin
                            addr_q      <= bus.req_addr;
                            victim_q    <= victim_d;
                            mem_ren_q   <= 1'b1;
                            mem_raddr_q <= bus.req_addr;
                            if (miss_q != '1) miss_q <= miss_q + 1'b1;
                            state_q     <= MREQ;
                        end
                    end
                end
                MREQ: begin
                    if (flush) flush_pend_q <= 1'b1;
                    state_q <= MWAIT;
                end
                MWAIT: begin
                    if (bus.mem_ready) begin
                        tag_q[victim_q]  <= addr_q;
                        data_q[victim_q] <= bus.mem_rdata;
                        resp_valid_q     <= 1'b1;
                        resp_data_q      <= bus.mem_rdata;
                        if (flush_pend_q || flush) valid_q <= '0;
                        else                       valid_q[victim_q] <= 1'b1;
                        flush_pend_q     <= 1'b0;
                        state_q          <= IDLE;
                    end else if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.mem_ren    = mem_ren_q;
    assign bus.mem_raddr  = mem_raddr_q;
    assign hit_count      = hit_q;
    assign miss_count     = miss_q;
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - self-checking bench for icache_assoc against a recency-list model
module tb_icache_assoc;
    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        flush2;
    logic [15:0] hit_count, miss_count;
    logic [1:0]  hit_count2, miss_count2;

    int errors;
    int checks;

    icache_assoc_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    icache_assoc_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

    icache_assoc #(.ENTRIES(N), .ADDR_W(16), .DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_assoc #(.ENTRIES(N), .ADDR_W(16), .DATA_W(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .flush(flush2),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lines plus a recency list, most recently used at the front.
    logic [15:0] m_tag [N];
    bit          m_valid [N];
    int          m_order [$];
    int          m_hits;
    int          m_misses;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h0301) ^ 16'h0105;
    endfunction

    function automatic void model_reset();
        m_order = {};
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_order.push_back(i);
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_touch(input int t);
        for (int k = 0; k < m_order.size(); k++) begin
            if (m_order[k] == t) begin
                m_order.delete(k);
                break;
            end
        end
        m_order.push_front(t);
    endfunction

    function automatic bit model_access(input logic [15:0] a, input bit flushed);
        int l;
        l = -1;
        for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == a) l = i;
        if (l >= 0) begin
            m_hits++;
            model_touch(l);
            return 1'b1;
        end
        m_misses++;
        for (int i = 0; i < N; i++) if (!m_valid[i] && l < 0) l = i;
        if (l < 0) l = m_order[m_order.size() - 1];
        m_tag[l]   = a;
        m_valid[l] = !flushed;
        if (flushed) model_flush();
        model_touch(l);
        return 1'b0;
    endfunction

    // Issues one fetch and plays the memory; reports when/what came back.
    task automatic do_fetch(input logic [15:0] addr, input int lat, input int flush_c,
                            output int c_resp, output logic [15:0] data,
                            output int rens, output logic [15:0] raddr);
        int ren_c;
        c_resp = -1; data = '0; rens = 0; raddr = '0; ren_c = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            bus.mem_ready = 1'b0;
            flush = 1'b0;
            if (bus.resp_valid) begin
                c_resp = c;
                data   = bus.resp_data;
                break;
            end
            if (bus.mem_ren) begin
                rens++;
                ren_c = c;
                raddr = bus.mem_raddr;
            end
            if (ren_c > 0 && c == ren_c + lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_word(raddr);
            end
            if (c == flush_c) flush = 1'b1;
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_addr = '0; bus.mem_ready = 0; bus.mem_rdata = '0;
        bus2.req_valid = 0; bus2.req_addr = '0; bus2.mem_ready = 0; bus2.mem_rdata = '0;
        flush = 0; flush2 = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL reset_mem_ren got %b want 0", bus.mem_ren); end
        checks++; if (bus.mem_raddr !== 16'h0) begin errors++; $display("FAIL reset_mem_raddr got %h want 0000", bus.mem_raddr); end
        checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_cold_miss();
        int c; logic [15:0] d; int r; logic [15:0] ra; bit h;
        h = model_access(16'h0000, 1'b0);
        do_fetch(16'h0000, 3, 0, c, d, r, ra);
        checks++; if (c !== 5) begin errors++; $display("FAIL cold_latency got %0d want 5", c); end
        checks++; if (r !== 1) begin errors++; $display("FAIL cold_mem_ren_count got %0d want 1", r); end
        checks++; if (ra !== 16'h0000) begin errors++; $display("FAIL cold_raddr got %h want 0000", ra); end
        checks++; if (d !== 16'h0105) begin errors++; $display("FAIL cold_data got %h want 0105", d); end
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL cold_miss_count got %0d want 1", miss_count); end
        h = model_access(16'h0000, 1'b0);
        do_fetch(16'h0000, 3, 0, c, d, r, ra);
        checks++; if (c !== 1 || r !== 0) begin errors++; $display("FAIL cold_rehit_latency got %0d (ren %0d) want 1 (ren 0)", c, r); end
        checks++; if (d !== 16'h0105) begin errors++; $display("FAIL cold_rehit_data got %h want 0105", d); end
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL cold_hit_count got %0d want 1", hit_count); end
    endtask

    task automatic test_lru();
        logic [15:0] seq [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd4, 16'd0, 16'd1};
        bit          exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int c; logic [15:0] d; int r; logic [15:0] ra; int lat; bit h;
        do_flush();
        for (int i = 0; i < 8; i++) begin
            lat = int'($urandom_range(1, 3));
            h = model_access(seq[i], 1'b0);
            do_fetch(seq[i], lat, 0, c, d, r, ra);
            checks++; if (c !== (exp[i] ? 1 : lat + 2)) begin errors++; $display("FAIL lru_latency step %0d addr %0d got %0d want %0d", i, seq[i], c, exp[i] ? 1 : lat + 2); end
            checks++; if (d !== mem_word(seq[i])) begin errors++; $display("FAIL lru_data step %0d got %h want %h", i, d, mem_word(seq[i])); end
        end
    endtask

    task automatic test_back_to_back();
        int c; logic [15:0] d; int r; logic [15:0] ra; bit h; int hits0;
        do_flush();
        for (int i = 0; i < 4; i++) begin
            h = model_access(16'(i), 1'b0);
            do_fetch(16'(i), 1, 0, c, d, r, ra);
        end
        hits0 = m_hits;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            h = model_access(16'(i), 1'b0);
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== mem_word(16'(i))) begin errors++; $display("FAIL b2b_resp %0d got v=%b d=%h want v=1 d=%h", i, bus.resp_valid, bus.resp_data, mem_word(16'(i))); end
            if (i < 3) bus.req_addr = 16'(i + 1);
            else       bus.req_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end got %b want 0", bus.resp_valid); end
        checks++; if (32'(hit_count) !== m_hits || m_hits !== hits0 + 4) begin errors++; $display("FAIL b2b_hit_count got %0d want %0d", hit_count, m_hits); end
    endtask

    task automatic test_flush_mwait();
        int c; logic [15:0] d; int r; logic [15:0] ra; bit h;
        do_flush();
        h = model_access(16'd7, 1'b1);
        do_fetch(16'd7, 3, 2, c, d, r, ra);
        checks++; if (c !== 5 || d !== mem_word(16'd7)) begin errors++; $display("FAIL flush_mwait_resp got c=%0d d=%h want c=5 d=%h", c, d, mem_word(16'd7)); end
        h = model_access(16'd7, 1'b0);
        do_fetch(16'd7, 2, 0, c, d, r, ra);
        checks++; if (c !== 4 || r !== 1) begin errors++; $display("FAIL flush_mwait_remiss got c=%0d ren=%0d want c=4 ren=1", c, r); end
    endtask

    task automatic test_random();
        int c; logic [15:0] d; int r; logic [15:0] ra; int lat; bit h; logic [15:0] a;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            a   = 16'($urandom_range(0, 7));
            lat = int'($urandom_range(1, 4));
            h   = model_access(a, 1'b0);
            do_fetch(a, lat, 0, c, d, r, ra);
            checks++; if (c !== (h ? 1 : lat + 2) || r !== (h ? 0 : 1)) begin errors++; $display("FAIL rand_timing iter %0d addr %0d got c=%0d ren=%0d want c=%0d ren=%0d", i, a, c, r, h ? 1 : lat + 2, h ? 0 : 1); end
            checks++; if (d !== mem_word(a) || (!h && ra !== a)) begin errors++; $display("FAIL rand_data iter %0d got d=%h raddr=%h want d=%h raddr=%h", i, d, ra, mem_word(a), a); end
        end
        checks++; if (32'(hit_count) !== m_hits || 32'(miss_count) !== m_misses) begin errors++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d", hit_count, miss_count, m_hits, m_misses); end
    endtask

    task automatic test_reset_mwait();
        int c; logic [15:0] d; int r; logic [15:0] ra; bit h; int seen;
        seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'd9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_word(16'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (bus.resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mwait_resp got %0d pulses want 0", seen); end
        checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL rst_mwait_counters got %0d/%0d want 0/0", hit_count, miss_count); end
        for (int i = 0; i < 2; i++) begin
            h = model_access(16'(i), 1'b0);
            do_fetch(16'(i), 1, 0, c, d, r, ra);
            checks++; if (c !== 3) begin errors++; $display("FAIL rst_mwait_invalid addr %0d got c=%0d want 3", i, c); end
        end
    endtask

    task automatic test_saturate();
        int got;
        got = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus2.req_valid = 1'b1;
            bus2.req_addr  = 16'(16'h10 + k);
            @(negedge clk);
            bus2.req_valid = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                bus2.mem_ready = 1'b0;
                if (bus2.resp_valid) begin
                    got++;
                    break;
                end
                if (c == 2) begin
                    bus2.mem_ready = 1'b1;
                    bus2.mem_rdata = mem_word(bus2.mem_raddr);
                end
                @(negedge clk);
            end
            bus2.mem_ready = 1'b0;
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL sat_responses got %0d want 5", got); end
        checks++; if (miss_count2 !== 2'd3) begin errors++; $display("FAIL sat_miss_count got %0d want 3", miss_count2); end
        @(negedge clk);
        flush2 = 1'b1;
        bus2.req_valid = 1'b1;
        bus2.req_addr  = 16'h10;
        #1;
        checks++; if (bus2.req_ready !== 1'b0) begin errors++; $display("FAIL sat_flush_ready got %b want 0", bus2.req_ready); end
        @(negedge clk);
        checks++; if (bus2.resp_valid !== 1'b0 || bus2.mem_ren !== 1'b0 || hit_count2 !== 2'd0) begin errors++; $display("FAIL sat_flush_no_accept got v=%b ren=%b hits=%0d want 0/0/0", bus2.resp_valid, bus2.mem_ren, hit_count2); end
        flush2 = 1'b0;
        bus2.req_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_cold_miss();
        test_lru();
        test_back_to_back();
        test_flush_mwait();
        test_random();
        test_reset_mwait();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule
